// File: rtl/adc_scan_sched.sv
// adc_scan_sched: round-robin scan scheduler for a 4-channel muxed parallel ADC.
// Each conversion runs mux settle -> WR strobe -> wait for end-of-conversion
// -> RD strobe -> result write, with one shared down-counter timing the steps.
module adc_scan_sched #(
    parameter int SETTLE_CYC = 8,
    parameter int WR_CYC     = 4,
    parameter int RD_CYC     = 4,
    parameter int TMO_CYC    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] ch_en,
    input  logic       intr_n,
    input  logic [7:0] adata,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [1:0] mux_sel,
    input  logic [1:0] rd_ch,
    output logic [7:0] rd_data,
    output logic       done,
    output logic [1:0] done_ch,
    output logic       busy,
    output logic [3:0] tmo_err,
    input  logic       err_clr
);

    localparam int MAX_A   = (SETTLE_CYC > WR_CYC) ? SETTLE_CYC : WR_CYC;
    localparam int MAX_B   = (RD_CYC > TMO_CYC) ? RD_CYC : TMO_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WR,
        WAIT,
        RD,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      sync;
    logic            intr_s;
    logic [1:0]      ptr;
    logic [1:0]      pick;
    logic            found;
    logic            start;
    logic            sel_load;
    logic            tmo_set;
    logic            tmo_hit;
    logic            cap_en;
    logic            res_wr;
    logic [7:0]      cap;
    logic [3:0][7:0] res;

    assign intr_s  = sync[1];
    assign start   = run && (ch_en != 4'd0);
    assign busy    = (state != IDLE);
    assign rd_data = res[rd_ch];

    // Round-robin pick: first enabled channel after the last one selected.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && ch_en[ptr + 2'(i)]) begin
                pick  = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state, shared counter reload and per-state control pulses.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_load  = 1'b0;
        tmo_set   = 1'b0;
        cap_en    = 1'b0;
        res_wr    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CW'(SETTLE_CYC - 1);
                    sel_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = WR;
                    cnt_nxt   = CW'(WR_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WR: begin
                if (cnt == '0) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(TMO_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT: begin
                if (!intr_s) begin
                    state_nxt = RD;
                    cnt_nxt   = CW'(RD_CYC - 1);
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                    tmo_set   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RD: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cap_en    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                res_wr = !tmo_hit;
                if (start) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CW'(SETTLE_CYC - 1);
                    sel_load  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, counter, and the timeout marker consumed in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tmo_hit <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == DONE)
                tmo_hit <= tmo_set;
        end
    end

    // Registered strobes (decoded from next state), channel select, capture,
    // result file, completion reporting and sticky timeout flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync    <= 2'b11;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            mux_sel <= '0;
            ptr     <= 2'd3;
            cap     <= '0;
            res     <= '0;
            done    <= 1'b0;
            done_ch <= '0;
            tmo_err <= '0;
        end else begin
            sync <= {sync[0], intr_n};
            cs_n <= !((state_nxt == WR) || (state_nxt == RD));
            wr_n <= (state_nxt != WR);
            rd_n <= (state_nxt != RD);
            if (sel_load) begin
                mux_sel <= pick;
                ptr     <= pick;
            end
            if (cap_en)
                cap <= adata;
            if (res_wr) begin
                res[mux_sel] <= cap;
                done_ch      <= mux_sel;
            end
            done <= res_wr;
            // A timeout landing in the same cycle as err_clr stays set.
            if (err_clr)
                tmo_err <= '0;
            if (tmo_set)
                tmo_err[mux_sel] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb_adc_scan_sched: self-checking bench with an ADC model, a conversion-level
// reference model, a round-robin vector table, directed corner cases and
// randomized scan segments.
module tb_adc_scan_sched;

    logic       clk = 1'b0;
    logic       rst, run, intr_n, err_clr;
    logic [3:0] ch_en;
    logic [7:0] adata;
    logic       cs_n, wr_n, rd_n;
    logic [1:0] mux_sel, rd_ch, done_ch;
    logic [7:0] rd_data;
    logic       done, busy;
    logic [3:0] tmo_err;

    int checks = 0;
    int failures = 0;

    adc_scan_sched #(
        .SETTLE_CYC(8), .WR_CYC(4), .RD_CYC(4), .TMO_CYC(1024)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .ch_en(ch_en), .intr_n(intr_n),
        .adata(adata), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .mux_sel(mux_sel), .rd_ch(rd_ch), .rd_data(rd_data), .done(done),
        .done_ch(done_ch), .busy(busy), .tmo_err(tmo_err), .err_clr(err_clr)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_next(input int last, input logic [3:0] en);
        for (int k = 1; k <= 4; k++)
            if (en[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction

    // ---------------- ADC model ----------------
    logic       adc_hang = 1'b0;
    int         adc_fix_dly = 3;
    int         adc_dmax = 0;
    logic [7:0] adc_val [4];
    int         adc_cnt;
    logic       adc_wr_q;

    // End-of-conversion N cycles after wr_n rises; released when rd_n goes low.
    initial begin
        intr_n = 1'b1; adata = 8'h00; adc_cnt = -1; adc_wr_q = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                intr_n = 1'b1; adc_cnt = -1; adc_wr_q = 1'b1;
            end else begin
                if (!adc_wr_q && wr_n && !adc_hang)
                    adc_cnt = (adc_fix_dly >= 0) ? adc_fix_dly : int'($urandom_range(adc_dmax, 0));
                if (adc_cnt == 0) begin
                    intr_n = 1'b0;
                    adata  = adc_val[mux_sel];
                end
                if (adc_cnt >= 0) adc_cnt--;
                if (!rd_n) intr_n = 1'b1;
                adc_wr_q = wr_n;
            end
        end
    end

    // ---------------- monitor + conversion-level reference ----------------
    int         m_last = 3, cur_ch = 0;
    logic       mon_wr_q = 1'b1, mon_done_q = 1'b0;
    int         wr_run = 0, rd_run = 0, last_wr = 0, last_rd = 0;
    int         bad_width = 0, viol = 0;
    int         n_starts = 0, n_done = 0, exp_done = 0;
    logic [7:0] exp_res [4];
    logic [3:0] exp_tmo = 4'h0;
    int         ch_log [$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_last = 3; wr_run = 0; rd_run = 0;
                mon_wr_q = 1'b1; mon_done_q = 1'b0;
                ch_log.delete();
            end else begin
                if (!wr_n && !rd_n) viol++;
                if ((!wr_n || !rd_n) && cs_n) viol++;
                if (done && mon_done_q) viol++;
                if (!wr_n) wr_run++;
                else if (wr_run != 0) begin
                    last_wr = wr_run; if (wr_run != 4) bad_width++; wr_run = 0;
                end
                if (!rd_n) rd_run++;
                else if (rd_run != 0) begin
                    last_rd = rd_run; if (rd_run != 4) bad_width++; rd_run = 0;
                end
                if (!wr_n && mon_wr_q) begin
                    cur_ch = rr_next(m_last, ch_en);
                    m_last = cur_ch;
                    chk("rr_channel", 32'(mux_sel), cur_ch);
                    ch_log.push_back(int'(mux_sel));
                    n_starts++;
                    if (adc_hang) exp_tmo[cur_ch] = 1'b1;
                    else begin
                        exp_done++;
                        exp_res[cur_ch] = adc_val[cur_ch];
                    end
                end
                if (done) begin
                    n_done++;
                    chk("done_ch", 32'(done_ch), cur_ch);
                end
                mon_wr_q = wr_n;
                mon_done_q = done;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; run = 1'b0; err_clr = 1'b0; adc_hang = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_starts = 0; n_done = 0; exp_done = 0; exp_tmo = 4'h0;
        for (int c = 0; c < 4; c++) exp_res[c] = 8'h00;
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        int k = 0;
        while (n_starts < n && k < budget) begin @(negedge clk); k++; end
        chk(nm, 32'(n_starts >= n), 1);
    endtask

    task automatic wait_done(input int n, input int budget, input string nm);
        int k = 0;
        while (n_done < n && k < budget) begin @(negedge clk); k++; end
        chk(nm, 32'(n_done >= n), 1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy && k < budget) begin @(negedge clk); k++; end
        chk(nm, 32'(busy), 0);
    endtask

    task automatic wait_wr_rise(input int budget, input string nm);
        int k = 0;
        logic prev = wr_n;
        logic seen = 1'b0;
        while (!seen && k < budget) begin
            @(negedge clk); k++;
            if (!prev && wr_n) seen = 1'b1;
            prev = wr_n;
        end
        chk(nm, 32'(seen), 1);
    endtask

    // ---------------- round-robin vector table ----------------
    typedef struct packed {
        logic [3:0]      en;
        logic [5:0][1:0] seq;  // seq[0] is the first channel converted
    } rr_vec_t;

    rr_vec_t tbl [6];

    initial begin
        int k, bad, nd, s0;
        rst = 1'b1; run = 1'b0; ch_en = 4'h0; err_clr = 1'b0; rd_ch = 2'd0;
        for (int c = 0; c < 4; c++) begin adc_val[c] = 8'h00; exp_res[c] = 8'h00; end

        tbl[0] = '{en: 4'b0001, seq: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[1] = '{en: 4'b1011, seq: {2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0}};
        tbl[2] = '{en: 4'b1111, seq: {2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[3] = '{en: 4'b1000, seq: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}};
        tbl[4] = '{en: 4'b0110, seq: {2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1}};
        tbl[5] = '{en: 4'b1100, seq: {2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2}};

        // Reset state
        do_reset();
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_mux_sel", 32'(mux_sel), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_ch", 32'(done_ch), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tmo_err", 32'(tmo_err), 0);
        for (int c = 0; c < 4; c++) begin
            rd_ch = 2'(c); #1;
            chk("rst_result", 32'(rd_data), 0);
        end

        // Round-robin table: order of service and per-channel distinct results
        for (int t = 0; t < 6; t++) begin
            do_reset();
            ch_en = tbl[t].en;
            adc_fix_dly = 3;
            for (int c = 0; c < 4; c++) adc_val[c] = 8'(8'h11 * (c + 1) + t);
            run = 1'b1;
            wait_starts(6, 400, "tbl_starts");
            run = 1'b0;
            wait_idle(200, "tbl_idle");
            for (int j = 0; j < 6; j++)
                chk("tbl_seq", (ch_log.size() > j) ? 32'(ch_log[j]) : 32'hFFFF, 32'(tbl[t].seq[j]));
            for (int c = 0; c < 4; c++) begin
                rd_ch = 2'(c); #1;
                chk("tbl_result", 32'(rd_data), tbl[t].en[c] ? 32'(adc_val[c]) : 32'h0);
            end
        end

        // Single channel, EOC 20 cycles after wr_n rises, data 0x5A; back-to-back
        do_reset();
        adc_val[0] = 8'h5A; adc_fix_dly = 20; ch_en = 4'b0001; run = 1'b1;
        wait_done(1, 300, "basic_done");
        chk("basic_wr_width", last_wr, 4);
        chk("basic_rd_width", last_rd, 4);
        chk("basic_done_ch", 32'(done_ch), 0);
        rd_ch = 2'd0; #1;
        chk("basic_rd_data", 32'(rd_data), 32'h5A);
        bad = 0; k = 0;
        while (n_starts < 2 && k < 100) begin
            @(negedge clk); k++;
            if (!busy) bad++;
        end
        chk("b2b_restart", 32'(n_starts >= 2), 1);
        chk("b2b_no_idle", bad, 0);

        // Timeout: latency from WAIT entry, no done, result kept, next start
        do_reset();
        adc_val[0] = 8'h33; adc_fix_dly = 2; ch_en = 4'b0001; run = 1'b1;
        wait_done(1, 300, "tmo_first_done");
        adc_hang = 1'b1;
        nd = n_done;
        wait_wr_rise(100, "tmo_wait_entry");
        k = 0;
        while (!tmo_err[0] && k < 1100) begin @(negedge clk); k++; end
        chk("tmo_latency", k, 1024);
        chk("tmo_bits", 32'(tmo_err), 32'h1);
        s0 = n_starts;
        wait_starts(s0 + 1, 40, "tmo_next_start");
        chk("tmo_no_done", n_done, nd);
        rd_ch = 2'd0; #1;
        chk("tmo_result_kept", 32'(rd_data), 32'h33);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk);
        chk("tmo_err_clr", 32'(tmo_err), 0);
        k = 0;
        while (!tmo_err[0] && k < 1100) begin @(negedge clk); k++; end
        chk("tmo_set_beats_clr", 32'(tmo_err[0]), 1);
        err_clr = 1'b0; adc_hang = 1'b0; run = 1'b0;
        wait_idle(1200, "tmo_idle");

        // run dropped during WAIT: conversion finishes, then IDLE
        do_reset();
        adc_val[0] = 8'h77; adc_fix_dly = 30; ch_en = 4'b0001; run = 1'b1;
        wait_wr_rise(100, "drop_wait_entry");
        repeat (5) @(negedge clk);
        run = 1'b0;
        wait_done(1, 100, "drop_done");
        chk("drop_done_ch", 32'(done_ch), 0);
        rd_ch = 2'd0; #1;
        chk("drop_result", 32'(rd_data), 32'h77);
        wait_idle(50, "drop_idle");
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || !cs_n || !wr_n || !rd_n) bad++;
        end
        chk("drop_stays_idle", bad, 0);

        // Reset asserted mid-RD
        do_reset();
        adc_val[0] = 8'h99; adc_fix_dly = 2; ch_en = 4'b0001; run = 1'b1; rd_ch = 2'd0;
        wait_done(1, 300, "rstrd_first_done");
        #1 chk("rstrd_pre_result", 32'(rd_data), 32'h99);
        k = 0;
        while (rd_n && k < 100) begin @(negedge clk); k++; end
        chk("rstrd_in_rd", 32'(rd_n), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstrd_rd_n", 32'(rd_n), 1);
        chk("rstrd_cs_n", 32'(cs_n), 1);
        chk("rstrd_wr_n", 32'(wr_n), 1);
        chk("rstrd_busy", 32'(busy), 0);
        chk("rstrd_result", 32'(rd_data), 0);

        // No channel enabled: stays IDLE; enabling one starts at channel 2
        do_reset();
        ch_en = 4'b0000; run = 1'b1; bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy || !cs_n || !wr_n || !rd_n) bad++;
        end
        chk("noen_idle", bad, 0);
        adc_fix_dly = 1; adc_val[2] = 8'hC3; ch_en = 4'b0100;
        wait_starts(1, 50, "noen_late_start");
        run = 1'b0;
        wait_idle(200, "noen_idle_end");
        rd_ch = 2'd2; #1;
        chk("noen_result", 32'(rd_data), 32'hC3);

        // Randomized scan segments against the conversion-level model
        do_reset();
        for (int s = 0; s < 8; s++) begin
            ch_en = 4'($urandom_range(15, 1));
            for (int c = 0; c < 4; c++) adc_val[c] = 8'($urandom);
            adc_hang = (s == 2) || ($urandom_range(9, 0) == 0);
            adc_fix_dly = -1;
            adc_dmax = int'($urandom_range(40, 0));
            @(negedge clk); err_clr = 1'b1;
            @(negedge clk); err_clr = 1'b0; exp_tmo = 4'h0;
            s0 = n_starts;
            run = 1'b1;
            wait_starts(s0 + (adc_hang ? 2 : int'($urandom_range(6, 2))), 4000, "rnd_starts");
            run = 1'b0;
            wait_idle(3000, "rnd_idle");
            chk("rnd_done_count", n_done, exp_done);
            chk("rnd_tmo_err", 32'(tmo_err), 32'(exp_tmo));
            for (int c = 0; c < 4; c++) begin
                rd_ch = 2'(c); #1;
                chk("rnd_result", 32'(rd_data), 32'(exp_res[c]));
            end
        end

        chk("protocol", viol, 0);
        chk("strobe_width", bad_width, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
